// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants
package cpu_pkg;
  typedef enum logic {REQ, HOLD} fetch_state_t;
  typedef logic [31:0] word_t;
  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam word_t PC_INC = 32'd4;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory request/response bus
interface fetch_unit_if import cpu_pkg::*; ();
  logic req;
  word_t addr;
  logic ready;
  word_t rdata;
  modport master(output req, addr, input ready, rdata);
  modport slave(input req, addr, output ready, rdata);
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: next PC mux (sequential, branch target, jump target)
module pc_next_sel import cpu_pkg::*; (
  input  word_t       pc,
  input  logic        branch_taken,
  input  word_t       branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output word_t       next_pc
);
  word_t p4;
  always_comb begin
    p4 = pc + PC_INC;
    next_pc = jump ? {p4[31:28], jump_index, 2'b00} : branch_taken ? p4 + (branch_offset << 2) : p4;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, imem request FSM and instruction hold for decode
module fetch_unit import cpu_pkg::*; #(
  parameter word_t RESET_PC = RESET_PC_DEFAULT,
  parameter int    CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  fetch_unit_if.master     imem,
  output word_t            instr,
  output logic             instr_valid,
  input  logic             instr_accept,
  output word_t            pc,
  input  logic             branch_taken,
  input  word_t            branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  output logic [CNT_W-1:0] fetch_count
);
  fetch_state_t state, state_n;
  word_t next_pc;
  logic capture, take;
  pc_next_sel u_sel (
    .pc(pc),
    .branch_taken(branch_taken),
    .branch_offset(branch_offset),
    .jump(jump),
    .jump_index(jump_index),
    .next_pc(next_pc)
  );
  always_comb begin
    capture = state == REQ && imem.ready;
    take = state == HOLD && instr_accept;
    state_n = capture ? HOLD : take ? REQ : state;
  end
  assign imem.req = state == REQ && !reset;
  assign imem.addr = pc;
  assign instr_valid = state == HOLD;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= REQ;
      pc <= RESET_PC;
      instr <= '0;
      fetch_count <= '0;
    end else begin
      state <= state_n;
      if (capture) instr <= imem.rdata;
      if (take) begin
        pc <= next_pc;
        fetch_count <= fetch_count + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch latency, stalls, redirects and reset
module tb_fetch_unit;
  logic clk = 0, reset;
  logic [31:0] instr, pc, branch_offset, fetch_count;
  logic instr_valid, instr_accept, branch_taken, jump;
  logic [25:0] jump_index;
  int tests = 0, fails = 0;
  fetch_unit_if imem();
  fetch_unit dut (
    .clk(clk), .reset(reset), .imem(imem), .instr(instr), .instr_valid(instr_valid),
    .instr_accept(instr_accept), .pc(pc), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
    .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [31:0] word);
    imem.ready = 1;
    imem.rdata = word;
    step();
    imem.ready = 0;
    chk("fetch_valid", {31'b0, instr_valid}, 1);
    chk("fetch_instr", instr, word);
  endtask
  task automatic accept(input logic bt, input logic [31:0] bo, input logic j, input logic [25:0] ji);
    branch_taken = bt;
    branch_offset = bo;
    jump = j;
    jump_index = ji;
    instr_accept = 1;
    step();
    instr_accept = 0;
    branch_taken = 0;
    branch_offset = 0;
    jump = 0;
    jump_index = 0;
  endtask
  initial begin
    reset = 1;
    imem.ready = 0;
    imem.rdata = 0;
    instr_accept = 0;
    branch_taken = 0;
    branch_offset = 0;
    jump = 0;
    jump_index = 0;
    step();
    chk("rst_req", {31'b0, imem.req}, 0);
    chk("rst_valid", {31'b0, instr_valid}, 0);
    chk("rst_pc", pc, 0);
    chk("rst_cnt", fetch_count, 0);
    chk("rst_instr", instr, 0);
    reset = 0;
    imem.ready = 1;
    imem.rdata = 32'h2008_0005;
    #1;
    chk("first_req", {31'b0, imem.req}, 1);
    chk("first_addr", imem.addr, 0);
    step();
    chk("lat_valid", {31'b0, instr_valid}, 1);
    chk("lat_instr", instr, 32'h2008_0005);
    chk("hold_noreq", {31'b0, imem.req}, 0);
    imem.ready = 0;
    accept(0, 0, 0, 0);
    chk("seq_pc", pc, 32'h4);
    chk("seq_cnt", fetch_count, 1);
    chk("seq_req", {31'b0, imem.req}, 1);
    repeat (3) begin
      step();
      chk("slow_req", {31'b0, imem.req}, 1);
      chk("slow_addr", imem.addr, 32'h4);
      chk("slow_valid", {31'b0, instr_valid}, 0);
    end
    fetch(32'h8c09_0000);
    accept(1, 32'h2, 0, 0);
    chk("br_setup", imem.addr, 32'h10);
    fetch(32'h1000_0003);
    accept(1, 32'h3, 0, 0);
    chk("br_pos", imem.addr, 32'h20);
    fetch(32'h1000_fffb);
    accept(1, 32'hFFFF_FFFB, 0, 0);
    chk("br_back", imem.addr, 32'h10);
    fetch(32'h1000_fffe);
    accept(1, 32'hFFFF_FFFE, 0, 0);
    chk("br_neg", imem.addr, 32'h0C);
    fetch(32'h1000_0000);
    accept(1, 32'h0FFF_FFFC, 0, 0);
    chk("br_far", imem.addr, 32'h4000_0000);
    fetch(32'h0800_0040);
    accept(1, 32'h0000_0100, 1, 26'h40);
    chk("jmp_prio", imem.addr, 32'h4000_0100);
    chk("jmp_cnt", fetch_count, 7);
    fetch(32'h1234_5678);
    repeat (5) begin
      step();
      chk("stall_instr", instr, 32'h1234_5678);
      chk("stall_pc", pc, 32'h4000_0100);
      chk("stall_cnt", fetch_count, 7);
      chk("stall_req", {31'b0, imem.req}, 0);
      chk("stall_valid", {31'b0, instr_valid}, 1);
    end
    accept(1, 32'h2FFF_FFBE, 0, 0);
    chk("wrap_setup", pc, 32'hFFFF_FFFC);
    fetch(32'h0000_0000);
    accept(0, 0, 0, 0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_cnt", fetch_count, 9);
    fetch(32'hABCD_0001);
    accept(0, 0, 0, 0);
    chk("pre_rst_pc", pc, 32'h4);
    chk("pre_rst_req", {31'b0, imem.req}, 1);
    #3;
    reset = 1;
    #1;
    chk("arst_req", {31'b0, imem.req}, 0);
    chk("arst_valid", {31'b0, instr_valid}, 0);
    chk("arst_cnt", fetch_count, 0);
    chk("arst_pc", pc, 0);
    chk("arst_instr", instr, 0);
    imem.ready = 1;
    imem.rdata = 32'hDEAD_BEEF;
    step();
    step();
    chk("rst_ignore", instr, 0);
    imem.ready = 0;
    #2;
    reset = 0;
    #1;
    chk("post_addr", imem.addr, 0);
    chk("post_req", {31'b0, imem.req}, 1);
    chk("post_valid", {31'b0, instr_valid}, 0);
    chk("post_instr", instr, 0);
    step();
    chk("post_nocap", {31'b0, instr_valid}, 0);
    fetch(32'h2008_0005);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
